// File: rtl/sym_seq_pkg.sv
// Shared types for the symbol-sequence transmitter.
// With SEQ_CHECK_EN defined, each FIFO entry also carries an expected response symbol.
package sym_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RSTP = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef logic [1:0] sym_t;

    typedef struct packed {
        logic mark;
        sym_t sym;
`ifdef SEQ_CHECK_EN
        sym_t exp;
`endif
    } entry_t;

    localparam logic [7:0] SENT_MAX = 8'd255;

    // Counter increment that sticks at SENT_MAX instead of wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] value);
        return (value == SENT_MAX) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/sym_fifo.sv
// First-word-fall-through FIFO with registered full/empty flags.
// A push is taken only when full is low at the edge, even if a pop happens in the same
// cycle. Flush empties the FIFO and overrides any push or pop in that cycle.
module sym_fifo #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             push_ok, pop_ok;

    // Next pointer/count values and the flags they imply for the following cycle.
    always_comb begin
        push_ok  = push && !full_q && !flush;
        pop_ok   = pop && !empty_q && !flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
        full_d  = (count_d == FULL_CNT);
        empty_d = (count_d == '0);
    end

    // Pointer, count and flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage array; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: rtl/sym_seq_tx.sv
// Programmable 2-bit symbol-sequence transmitter feeding a downstream FSM's input.
// Queued symbols are played one per HOLD_CYCLES accepted cycles; marked symbols are
// preceded by a one-cycle fsm_reset pulse. Define SEQ_CHECK_EN to add the response checker
// (wr_exp, obs_out, mismatch, err_cnt).
module sym_seq_tx
    import sym_seq_pkg::*;
#(
    parameter int   DEPTH       = 32,
    parameter int   HOLD_CYCLES = 1,
    parameter sym_t IDLE_SYM    = 2'b00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [1:0] wr_sym,
    input  logic       wr_mark,
`ifdef SEQ_CHECK_EN
    input  logic [1:0] wr_exp,
    input  logic [1:0] obs_out,
    output logic       mismatch,
    output logic [7:0] err_cnt,
`endif
    output logic       full,
    output logic       empty,
    output logic       ovf,
    input  logic       start,
    input  logic       abort,
    input  logic       sym_ready,
    output logic [1:0] sym_out,
    output logic       sym_valid,
    output logic       fsm_reset,
    output logic       busy,
    output logic       done,
    output logic [7:0] sent_cnt
);

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    entry_t        wr_entry, head;
    logic          fifo_full, fifo_empty, fifo_pop, fifo_flush;
    logic          load_head, last_accept;

    state_t        state_q, state_d;
    sym_t          sym_reg_q, sym_reg_d;
    sym_t          sym_out_q, sym_out_d;
    logic          sym_valid_q, sym_valid_d;
    logic          fsm_reset_q, fsm_reset_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          ovf_q, ovf_d;
    logic [7:0]    sent_cnt_q, sent_cnt_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
`ifdef SEQ_CHECK_EN
    sym_t          exp_reg_q, exp_reg_d;
    sym_t          chk_exp_q, chk_exp_d;
    logic          chk_pend_q, chk_pend_d;
    logic          mismatch_q, mismatch_d;
    logic [7:0]    err_cnt_q, err_cnt_d;
    logic [7:0]    err_base;
`endif

    assign wr_entry.mark = wr_mark;
    assign wr_entry.sym  = wr_sym;
`ifdef SEQ_CHECK_EN
    assign wr_entry.exp  = wr_exp;
`endif

    sym_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(entry_t))
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (fifo_flush),
        .push  (wr_en),
        .pop   (fifo_pop),
        .wdata (wr_entry),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Playback FSM next-state and registered-output logic; abort overrides everything.
    always_comb begin
        state_d     = state_q;
        sym_reg_d   = sym_reg_q;
        sym_out_d   = sym_out_q;
        sym_valid_d = sym_valid_q;
        fsm_reset_d = 1'b0;
        done_d      = 1'b0;
        sent_cnt_d  = sent_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        ovf_d       = ovf_q | (wr_en & fifo_full);
        fifo_flush  = 1'b0;
        load_head   = 1'b0;
        last_accept = 1'b0;
        if (abort) begin
            fifo_flush  = 1'b1;
            state_d     = IDLE;
            sym_out_d   = IDLE_SYM;
            sym_valid_d = 1'b0;
            hold_cnt_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    sym_out_d   = IDLE_SYM;
                    sym_valid_d = 1'b0;
                    if (start) begin
                        sent_cnt_d = '0;
                        hold_cnt_d = '0;
                        if (!fifo_empty) begin
                            load_head = 1'b1;
                        end else begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end
                    end
                end
                RSTP: begin
                    state_d     = SEND;
                    sym_valid_d = 1'b1;
                    sym_out_d   = sym_reg_q;
                end
                SEND: begin
                    if (sym_ready) begin
                        if (hold_cnt_q == HOLD_LAST) begin
                            last_accept = 1'b1;
                            hold_cnt_d  = '0;
                            if (!fifo_empty) begin
                                load_head = 1'b1;
                            end else begin
                                state_d     = DONE;
                                done_d      = 1'b1;
                                sym_valid_d = 1'b0;
                                sym_out_d   = IDLE_SYM;
                            end
                        end else begin
                            hold_cnt_d = hold_cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d     = IDLE;
                    sym_valid_d = 1'b0;
                    sym_out_d   = IDLE_SYM;
                end
            endcase
        end
        if (last_accept) sent_cnt_d = sat_inc(sent_cnt_q);
        if (load_head) begin
            sym_reg_d = head.sym;
            if (head.mark) begin
                state_d     = RSTP;
                fsm_reset_d = 1'b1;
                sym_valid_d = 1'b0;
                sym_out_d   = IDLE_SYM;
            end else begin
                state_d     = SEND;
                sym_valid_d = 1'b1;
                sym_out_d   = head.sym;
            end
        end
        fifo_pop = load_head;
        busy_d   = (state_d != IDLE);
    end

`ifdef SEQ_CHECK_EN
    // Response checker: compares obs_out one cycle after each symbol's final accepted cycle.
    always_comb begin
        exp_reg_d  = load_head ? head.exp : exp_reg_q;
        chk_pend_d = last_accept;
        chk_exp_d  = exp_reg_q;
        mismatch_d = chk_pend_q && !abort && (obs_out != chk_exp_q);
        err_base   = (state_q == IDLE && start && !abort) ? 8'd0 : err_cnt_q;
        err_cnt_d  = mismatch_d ? sat_inc(err_base) : err_base;
    end
`endif

    // State and output registers, all cleared by the synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            sym_reg_q   <= IDLE_SYM;
            sym_out_q   <= IDLE_SYM;
            sym_valid_q <= 1'b0;
            fsm_reset_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
            sent_cnt_q  <= '0;
            hold_cnt_q  <= '0;
`ifdef SEQ_CHECK_EN
            exp_reg_q   <= '0;
            chk_exp_q   <= '0;
            chk_pend_q  <= 1'b0;
            mismatch_q  <= 1'b0;
            err_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            sym_reg_q   <= sym_reg_d;
            sym_out_q   <= sym_out_d;
            sym_valid_q <= sym_valid_d;
            fsm_reset_q <= fsm_reset_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ovf_q       <= ovf_d;
            sent_cnt_q  <= sent_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
`ifdef SEQ_CHECK_EN
            exp_reg_q   <= exp_reg_d;
            chk_exp_q   <= chk_exp_d;
            chk_pend_q  <= chk_pend_d;
            mismatch_q  <= mismatch_d;
            err_cnt_q   <= err_cnt_d;
`endif
        end
    end

    assign full      = fifo_full;
    assign empty     = fifo_empty;
    assign ovf       = ovf_q;
    assign sym_out   = sym_out_q;
    assign sym_valid = sym_valid_q;
    assign fsm_reset = fsm_reset_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign sent_cnt  = sent_cnt_q;
`ifdef SEQ_CHECK_EN
    assign mismatch  = mismatch_q;
    assign err_cnt   = err_cnt_q;
`endif

endmodule

// File: tb/tb_sym_seq_tx.sv
// Directed bench for sym_seq_tx: a default instance (DEPTH=32, HOLD_CYCLES=1) and a
// small instance (DEPTH=4, HOLD_CYCLES=2) sharing clock and reset.
module tb_sym_seq_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       wr_en, wr_mark, start, abort, sym_ready;
    logic [1:0] wr_sym;
    logic       full, empty, ovf, sym_valid, fsm_reset, busy, done;
    logic [1:0] sym_out;
    logic [7:0] sent_cnt;

    logic       b_wr_en, b_wr_mark, b_start, b_abort, b_sym_ready;
    logic [1:0] b_wr_sym;
    logic       b_full, b_empty, b_ovf, b_sym_valid, b_fsm_reset, b_busy, b_done;
    logic [1:0] b_sym_out;
    logic [7:0] b_sent_cnt;

    int checks = 0;
    int errors = 0;

    sym_seq_tx dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sym(wr_sym), .wr_mark(wr_mark),
        .full(full), .empty(empty), .ovf(ovf), .start(start), .abort(abort),
        .sym_ready(sym_ready), .sym_out(sym_out), .sym_valid(sym_valid),
        .fsm_reset(fsm_reset), .busy(busy), .done(done), .sent_cnt(sent_cnt)
    );

    sym_seq_tx #(.DEPTH(4), .HOLD_CYCLES(2), .IDLE_SYM(2'b00)) dut_h2 (
        .clk(clk), .reset(reset), .wr_en(b_wr_en), .wr_sym(b_wr_sym), .wr_mark(b_wr_mark),
        .full(b_full), .empty(b_empty), .ovf(b_ovf), .start(b_start), .abort(b_abort),
        .sym_ready(b_sym_ready), .sym_out(b_sym_out), .sym_valid(b_sym_valid),
        .fsm_reset(b_fsm_reset), .busy(b_busy), .done(b_done), .sent_cnt(b_sent_cnt)
    );

    // Advance to just after the next rising edge, where outputs are stable.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_a(input logic [1:0] s, input logic m);
        wr_en = 1'b1; wr_sym = s; wr_mark = m;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic push_b(input logic [1:0] s, input logic m);
        b_wr_en = 1'b1; b_wr_sym = s; b_wr_mark = m;
        tick();
        b_wr_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++;
        if ({sym_out, sym_valid, fsm_reset, busy, done, ovf} !== 7'b00_00000) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got out=%b valid=%b rst=%b busy=%b done=%b ovf=%b, expected all 0",
                     sym_out, sym_valid, fsm_reset, busy, done, ovf);
        end
        checks++;
        if (sent_cnt !== 8'd0) begin
            errors++;
            $display("[TB] FAIL reset_sent_cnt: got %0d, expected 0", sent_cnt);
        end
        checks++;
        if ({empty, full} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL reset_fifo_flags: got empty=%b full=%b, expected empty=1 full=0", empty, full);
        end
        checks++;
        if ({b_empty, b_ovf, b_busy, b_sym_valid} !== 4'b1000) begin
            errors++;
            $display("[TB] FAIL reset_h2: got empty=%b ovf=%b busy=%b valid=%b, expected 1 0 0 0",
                     b_empty, b_ovf, b_busy, b_sym_valid);
        end
    endtask

    task automatic test_basic_sequence();
        logic [1:0] eo [5] = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b00};
        logic       ev [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic       ed [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic       eb [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [7:0] ec [5] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd3};
        sym_ready = 1'b1;
        push_a(2'b00, 1'b0);
        push_a(2'b01, 1'b0);
        push_a(2'b10, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({sym_valid, sym_out, fsm_reset, done, busy, sent_cnt} !== {ev[i], eo[i], 1'b0, ed[i], eb[i], ec[i]}) begin
                errors++;
                $display("[TB] FAIL basic_cycle%0d: got valid=%b out=%b rst=%b done=%b busy=%b sent=%0d, expected valid=%b out=%b rst=0 done=%b busy=%b sent=%0d",
                         i, sym_valid, sym_out, fsm_reset, done, busy, sent_cnt, ev[i], eo[i], ed[i], eb[i], ec[i]);
            end
            tick();
        end
    endtask

    task automatic test_marked_sequence();
        logic [1:0] eo [7] = '{2'b00, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00};
        logic       ev [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic       er [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic       ed [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic       eb [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [7:0] ec [7] = '{8'd0, 8'd0, 8'd1, 8'd2, 8'd2, 8'd3, 8'd3};
        sym_ready = 1'b1;
        push_a(2'b11, 1'b1);
        push_a(2'b00, 1'b0);
        push_a(2'b11, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            checks++;
            if ({sym_valid, sym_out, fsm_reset, done, busy, sent_cnt} !== {ev[i], eo[i], er[i], ed[i], eb[i], ec[i]}) begin
                errors++;
                $display("[TB] FAIL marked_cycle%0d: got valid=%b out=%b rst=%b done=%b busy=%b sent=%0d, expected valid=%b out=%b rst=%b done=%b busy=%b sent=%0d",
                         i, sym_valid, sym_out, fsm_reset, done, busy, sent_cnt, ev[i], eo[i], er[i], ed[i], eb[i], ec[i]);
            end
            tick();
        end
    endtask

    task automatic test_push_during_playback();
        logic       rdy [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        logic [1:0] eo  [4] = '{2'b01, 2'b01, 2'b11, 2'b00};
        logic       ev  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic       ed  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [7:0] ec  [4] = '{8'd0, 8'd0, 8'd1, 8'd2};
        push_a(2'b01, 1'b0);
        sym_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sym_ready = rdy[i];
            if (i == 0) begin
                wr_en = 1'b1; wr_sym = 2'b11; wr_mark = 1'b0;
            end
            checks++;
            if ({sym_valid, sym_out, done, sent_cnt} !== {ev[i], eo[i], ed[i], ec[i]}) begin
                errors++;
                $display("[TB] FAIL live_push_cycle%0d: got valid=%b out=%b done=%b sent=%0d, expected valid=%b out=%b done=%b sent=%0d",
                         i, sym_valid, sym_out, done, sent_cnt, ev[i], eo[i], ed[i], ec[i]);
            end
            tick();
            wr_en = 1'b0;
        end
        sym_ready = 1'b1;
    endtask

    task automatic test_empty_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if ({done, busy, sym_valid, sent_cnt} !== {1'b1, 1'b1, 1'b0, 8'd0}) begin
            errors++;
            $display("[TB] FAIL empty_start: got done=%b busy=%b valid=%b sent=%0d, expected done=1 busy=1 valid=0 sent=0",
                     done, busy, sym_valid, sent_cnt);
        end
        tick();
        checks++;
        if ({done, busy} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL empty_start_idle: got done=%b busy=%b, expected 0 0", done, busy);
        end
    endtask

    task automatic test_hold_cycles();
        logic       rdy [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic [1:0] eo  [4] = '{2'b10, 2'b10, 2'b10, 2'b00};
        logic       ev  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic       ed  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [7:0] ec  [4] = '{8'd0, 8'd0, 8'd0, 8'd1};
        push_b(2'b10, 1'b0);
        b_sym_ready = 1'b1;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            b_sym_ready = rdy[i];
            checks++;
            if ({b_sym_valid, b_sym_out, b_done, b_sent_cnt} !== {ev[i], eo[i], ed[i], ec[i]}) begin
                errors++;
                $display("[TB] FAIL hold2_cycle%0d: got valid=%b out=%b done=%b sent=%0d, expected valid=%b out=%b done=%b sent=%0d",
                         i, b_sym_valid, b_sym_out, b_done, b_sent_cnt, ev[i], eo[i], ed[i], ec[i]);
            end
            tick();
        end
    endtask

    task automatic test_overflow();
        logic [1:0] syms [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
        logic [1:0] exp_sym;
        for (int i = 0; i < 3; i++) push_b(syms[i], 1'b0);
        checks++;
        if (b_full !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ovf_not_full_at_3: got full=%b, expected 0", b_full);
        end
        push_b(syms[3], 1'b0);
        checks++;
        if ({b_full, b_ovf} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL ovf_full_at_depth: got full=%b ovf=%b, expected full=1 ovf=0", b_full, b_ovf);
        end
        push_b(2'b10, 1'b1);
        checks++;
        if ({b_full, b_ovf} !== 2'b11) begin
            errors++;
            $display("[TB] FAIL ovf_rejected_push: got full=%b ovf=%b, expected full=1 ovf=1", b_full, b_ovf);
        end
        b_sym_ready = 1'b1;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp_sym = syms[i / 2];
            checks++;
            if ({b_sym_valid, b_sym_out, b_fsm_reset} !== {1'b1, exp_sym, 1'b0}) begin
                errors++;
                $display("[TB] FAIL ovf_play_cycle%0d: got valid=%b out=%b rst=%b, expected valid=1 out=%b rst=0",
                         i, b_sym_valid, b_sym_out, b_fsm_reset, exp_sym);
            end
            tick();
        end
        checks++;
        if ({b_done, b_sent_cnt, b_ovf, b_empty} !== {1'b1, 8'd4, 1'b1, 1'b1}) begin
            errors++;
            $display("[TB] FAIL ovf_play_end: got done=%b sent=%0d ovf=%b empty=%b, expected done=1 sent=4 ovf=1 empty=1",
                     b_done, b_sent_cnt, b_ovf, b_empty);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (b_ovf !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ovf_cleared_by_reset: got ovf=%b, expected 0", b_ovf);
        end
    endtask

    task automatic test_abort();
        logic [1:0] syms [5] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b01};
        sym_ready = 1'b1;
        for (int i = 0; i < 5; i++) push_a(syms[i], 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        checks++;
        if ({sym_valid, sym_out, sent_cnt} !== {1'b1, 2'b10, 8'd2}) begin
            errors++;
            $display("[TB] FAIL abort_pre: got valid=%b out=%b sent=%0d, expected valid=1 out=10 sent=2",
                     sym_valid, sym_out, sent_cnt);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if ({busy, sym_valid, sym_out, done, empty, sent_cnt} !== {1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 8'd2}) begin
            errors++;
            $display("[TB] FAIL abort_next: got busy=%b valid=%b out=%b done=%b empty=%b sent=%0d, expected busy=0 valid=0 out=00 done=0 empty=1 sent=2",
                     busy, sym_valid, sym_out, done, empty, sent_cnt);
        end
        tick();
        checks++;
        if ({done, busy, empty} !== 3'b001) begin
            errors++;
            $display("[TB] FAIL abort_no_done: got done=%b busy=%b empty=%b, expected 0 0 1", done, busy, empty);
        end
        for (int i = 0; i < 5; i++) push_a(syms[i], 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({busy, sym_valid, sym_out, fsm_reset, done, ovf, empty, full, sent_cnt} !==
            {1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0}) begin
            errors++;
            $display("[TB] FAIL reset_mid_play: got busy=%b valid=%b out=%b rst=%b done=%b ovf=%b empty=%b full=%b sent=%0d, expected all reset values",
                     busy, sym_valid, sym_out, fsm_reset, done, ovf, empty, full, sent_cnt);
        end
    endtask

    initial begin
        reset = 1'b1;
        wr_en = 1'b0; wr_sym = 2'b00; wr_mark = 1'b0;
        start = 1'b0; abort = 1'b0; sym_ready = 1'b1;
        b_wr_en = 1'b0; b_wr_sym = 2'b00; b_wr_mark = 1'b0;
        b_start = 1'b0; b_abort = 1'b0; b_sym_ready = 1'b1;
        $display("[TB] starting sym_seq_tx bench");
        test_reset();
        test_basic_sequence();
        test_marked_sequence();
        test_push_during_playback();
        test_empty_start();
        test_hold_cycles();
        test_overflow();
        test_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
